reorder_buffer: RTL and testbench
=================================

// Module: reorder_buffer
// PURPOSE
//  In-order commit buffer for the out-of-order core. Allocates one entry per cycle at dispatch,
//  accepts up to two out-of-order completions per cycle from execution units, and retires up to
//  two completed entries per cycle in program order. Drives the two architectural register-file
//  write ports (rd1/rd2) directly; slot 2 is always the younger instruction.
// PARAMETERS
//  DEPTH   16   entry count; power of two, >= 4
//  TAG_W   4    log2(DEPTH); width of the entry tag/pointers
// PORTS
//  clk            in   1      clock, all state on posedge
//  reset          in   1      asynchronous, active-high reset
//  flush          in   1      sync clear of all entries (mispredict/exception)
//  alloc_valid    in   1      dispatch requests an entry
//  alloc_rd       in   5      destination arch register
//  alloc_we       in   1      instruction writes rd
//  alloc_ready    out  1      entry available (count < DEPTH)
//  alloc_tag      out  TAG_W  tag of entry allocated this cycle (= tail)
//  cmpl0_valid    in   1      completion port 0 valid
//  cmpl0_tag      in   TAG_W  completing entry
//  cmpl0_data     in   32     result value
//  cmpl1_valid/cmpl1_tag/cmpl1_data  in 1/TAG_W/32  completion port 1, same meaning
//  regWrite1      out  1      retire slot 1 write enable (to reg file)
//  rd1            out  5      retire slot 1 destination
//  rd1_data       out  32     retire slot 1 value
//  regWrite2/rd2/rd2_data     out 1/5/32  retire slot 2 (younger), same meaning
//  retire_count   out  2      entries retired in the last cycle (0..2)
//  rob_empty      out  1      count == 0
// BEHAVIOUR
//  - Reset: head=tail=count=0, all valid/done bits 0; all outputs 0 except alloc_ready=1, rob_empty=1.
//  - Per entry: valid, done, we, rd[4:0], data[31:0]. Pointers wrap mod DEPTH.
//  - Alloc: fires when alloc_valid && alloc_ready; writes entry[tail] (valid=1, done=0), tail+1.
//    alloc_ready/rob_empty derive from registered count (retires in same cycle not credited).
//  - Complete: on valid port with entry[tag].valid, set done=1, data=cmplN_data. Tag of an invalid
//    entry is ignored. Both ports same tag same cycle: port 1 wins.
//  - Completion landing in cycle N is retirable from cycle N+1 (done bit read from state only; no
//    bypass of same-cycle completion into retire).
//  - Retire decision each cycle: slot1 = entry[head] valid&&done; slot2 = slot1 && entry[head+1]
//    valid&&done. Retired entries cleared (valid=0), head += n, count = count + alloc - n.
//  - Retire outputs are registered: decision at edge E appears on regWrite*/rd*/rd*_data after E,
//    held exactly one cycle, so reg file commits at E+1. regWriteK = slotK && entry.we.
//    Unused slot drives regWrite=0, rd=0, data=0. retire_count registered alongside.
//  - Same rd in both slots: both driven; slot 2 (younger) must win at the reg file.
//  - Full (count==DEPTH): alloc_ready=0, alloc_valid ignored. Alloc + retire same cycle at full
//    does not occur (ready low). Empty: no retire.
//  - flush: priority over alloc/complete/retire same cycle; next state = reset state; retire
//    outputs 0 in following cycle. Outputs already registered before flush edge are unaffected.
//  - reset mid-operation: immediate return to reset state regardless of clock.
// TESTING
//  1. Reset, alloc 3 (rd=5,6,7 we=1), complete tags 0,1,2 one/cycle -> regWrite1 pulses rd=5,6,7
//     one per cycle, each 1 cycle after its completion edge; rob_empty=1 at end.
//  2. Alloc tags 0,1; complete tag1 (0xBEEF) then tag0 (0x1234) -> nothing retires until tag0
//     done; then same cycle rd1=tag0 0x1234, rd2=tag1 0xBEEF, retire_count=2.
//  3. Fill DEPTH=16 entries -> alloc_ready=0 at count 16, extra alloc ignored; complete head ->
//     retire, alloc_ready=1 next cycle, next alloc_tag = 0 after wrap.
//  4. Both ports complete tag 3 with 0xAAAA/0x5555 -> tag 3 retires with 0x5555.
//  5. Entry with we=0 completes -> retire_count=1, regWrite1=0, rd1=0.
//  6. 5 entries pending, 2 done; assert flush with completions -> no retire, count=0,
//     rob_empty=1, next alloc_tag=0; async reset mid-run -> outputs 0 immediately.

Source files
------------

// File: rtl/reorder_buffer.sv
// Reorder buffer: in-order commit for the out-of-order core.
//
// Allocates one entry per cycle at dispatch, accepts up to two out-of-order completions per
// cycle, and retires up to two completed entries per cycle in program order. Retire results
// drive the two architectural register-file write ports; slot 2 is always the younger entry,
// so when both slots target the same rd the reg file must let slot 2 win.
//
// Ports
//   clk, reset               clock; asynchronous active-high reset
//   flush                    synchronous clear of all entries (mispredict/exception)
//   alloc_valid/rd/we        dispatch request, destination register, write-enable
//   alloc_ready, alloc_tag   entry available (count < DEPTH); tag given to this cycle's alloc
//   cmpl0_*/cmpl1_*          completion ports (valid, tag, 32-bit result); port 1 wins ties
//   regWrite1/rd1/rd1_data   retire slot 1 (older), registered
//   regWrite2/rd2/rd2_data   retire slot 2 (younger), registered
//   retire_count             entries retired at the last edge (0..2)
//   rob_empty                count == 0
module reorder_buffer #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned TAG_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             alloc_valid,
  input  logic [4:0]       alloc_rd,
  input  logic             alloc_we,
  output logic             alloc_ready,
  output logic [TAG_W-1:0] alloc_tag,
  input  logic             cmpl0_valid,
  input  logic [TAG_W-1:0] cmpl0_tag,
  input  logic [31:0]      cmpl0_data,
  input  logic             cmpl1_valid,
  input  logic [TAG_W-1:0] cmpl1_tag,
  input  logic [31:0]      cmpl1_data,
  output logic             regWrite1,
  output logic [4:0]       rd1,
  output logic [31:0]      rd1_data,
  output logic             regWrite2,
  output logic [4:0]       rd2,
  output logic [31:0]      rd2_data,
  output logic [1:0]       retire_count,
  output logic             rob_empty
);

  localparam logic [TAG_W:0] DepthCnt = (TAG_W+1)'(DEPTH);

  // Control state (reset)
  logic [DEPTH-1:0] valid_q, valid_d;
  logic [DEPTH-1:0] done_q, done_d;
  logic [TAG_W-1:0] head_q, head_d;
  logic [TAG_W-1:0] tail_q, tail_d;
  logic [TAG_W:0]   count_q, count_d;

  // Payload (not reset: only meaningful while the matching valid bit is set)
  logic [DEPTH-1:0] we_q, we_d;
  logic [4:0]       rd_q [DEPTH];
  logic [4:0]       rd_d [DEPTH];
  logic [31:0]      data_q [DEPTH];
  logic [31:0]      data_d [DEPTH];

  // Registered retire outputs
  logic        rw1_q, rw1_d;
  logic [4:0]  rd1_q, rd1_d;
  logic [31:0] dat1_q, dat1_d;
  logic        rw2_q, rw2_d;
  logic [4:0]  rd2_q, rd2_d;
  logic [31:0] dat2_q, dat2_d;
  logic [1:0]  rc_q, rc_d;

  logic             alloc_fire;
  logic [TAG_W-1:0] head_p1;
  logic             slot1, slot2;
  logic [1:0]       n_retire;

  assign alloc_ready = (count_q < DepthCnt);
  assign rob_empty   = (count_q == '0);
  assign alloc_tag   = tail_q;
  assign alloc_fire  = alloc_valid & alloc_ready;

  // Retire decision reads registered done bits only, so a completion is retirable one cycle
  // after it lands. Empty buffer has valid[head]=0, so nothing retires.
  assign head_p1  = head_q + TAG_W'(1);
  assign slot1    = valid_q[head_q] & done_q[head_q];
  assign slot2    = slot1 & valid_q[head_p1] & done_q[head_p1];
  assign n_retire = slot2 ? 2'd2 : (slot1 ? 2'd1 : 2'd0);

  always_comb begin
    valid_d = valid_q;
    done_d  = done_q;
    we_d    = we_q;
    rd_d    = rd_q;
    data_d  = data_q;
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;

    rw1_d  = 1'b0;
    rd1_d  = '0;
    dat1_d = '0;
    rw2_d  = 1'b0;
    rd2_d  = '0;
    dat2_d = '0;
    rc_d   = 2'd0;

    if (flush) begin
      valid_d = '0;
      done_d  = '0;
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      // Completions; port 1 applied last so it wins a same-tag collision.
      if (cmpl0_valid && valid_q[cmpl0_tag]) begin
        done_d[cmpl0_tag] = 1'b1;
        data_d[cmpl0_tag] = cmpl0_data;
      end
      if (cmpl1_valid && valid_q[cmpl1_tag]) begin
        done_d[cmpl1_tag] = 1'b1;
        data_d[cmpl1_tag] = cmpl1_data;
      end

      if (slot1) begin
        valid_d[head_q] = 1'b0;
        done_d[head_q]  = 1'b0;
        rw1_d           = we_q[head_q];
        rd1_d           = we_q[head_q] ? rd_q[head_q] : 5'd0;
        dat1_d          = we_q[head_q] ? data_q[head_q] : 32'd0;
      end
      if (slot2) begin
        valid_d[head_p1] = 1'b0;
        done_d[head_p1]  = 1'b0;
        rw2_d            = we_q[head_p1];
        rd2_d            = we_q[head_p1] ? rd_q[head_p1] : 5'd0;
        dat2_d           = we_q[head_p1] ? data_q[head_p1] : 32'd0;
      end
      rc_d = n_retire;

      // Tail never aliases a retiring head: that needs a full buffer, where alloc is blocked.
      if (alloc_fire) begin
        valid_d[tail_q] = 1'b1;
        done_d[tail_q]  = 1'b0;
        we_d[tail_q]    = alloc_we;
        rd_d[tail_q]    = alloc_rd;
        data_d[tail_q]  = '0;
      end

      head_d  = head_q + TAG_W'(n_retire);
      tail_d  = tail_q + TAG_W'(alloc_fire);
      count_d = count_q + (TAG_W+1)'(alloc_fire) - (TAG_W+1)'(n_retire);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_q <= '0;
      done_q  <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      rw1_q   <= 1'b0;
      rd1_q   <= '0;
      dat1_q  <= '0;
      rw2_q   <= 1'b0;
      rd2_q   <= '0;
      dat2_q  <= '0;
      rc_q    <= 2'd0;
    end else begin
      valid_q <= valid_d;
      done_q  <= done_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      rw1_q   <= rw1_d;
      rd1_q   <= rd1_d;
      dat1_q  <= dat1_d;
      rw2_q   <= rw2_d;
      rd2_q   <= rd2_d;
      dat2_q  <= dat2_d;
      rc_q    <= rc_d;
    end
  end

  always_ff @(posedge clk) begin
    we_q   <= we_d;
    rd_q   <= rd_d;
    data_q <= data_d;
  end

  assign regWrite1    = rw1_q;
  assign rd1          = rd1_q;
  assign rd1_data     = dat1_q;
  assign regWrite2    = rw2_q;
  assign rd2          = rd2_q;
  assign rd2_data     = dat2_q;
  assign retire_count = rc_q;

endmodule

// File: tb/tb_reorder_buffer.sv
// Self-checking bench for reorder_buffer. Inputs are driven on the falling edge; a monitor
// samples retire outputs just after each rising edge and checks them against a scoreboard of
// expected retirements in program order (pushed at allocation, data filled at completion).
module tb_reorder_buffer;

  logic        clk;
  logic        reset;
  logic        flush;
  logic        alloc_valid;
  logic [4:0]  alloc_rd;
  logic        alloc_we;
  logic        alloc_ready;
  logic [3:0]  alloc_tag;
  logic        cmpl0_valid;
  logic [3:0]  cmpl0_tag;
  logic [31:0] cmpl0_data;
  logic        cmpl1_valid;
  logic [3:0]  cmpl1_tag;
  logic [31:0] cmpl1_data;
  logic        regWrite1;
  logic [4:0]  rd1;
  logic [31:0] rd1_data;
  logic        regWrite2;
  logic [4:0]  rd2;
  logic [31:0] rd2_data;
  logic [1:0]  retire_count;
  logic        rob_empty;

  reorder_buffer #(
    .DEPTH(16),
    .TAG_W(4)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .flush       (flush),
    .alloc_valid (alloc_valid),
    .alloc_rd    (alloc_rd),
    .alloc_we    (alloc_we),
    .alloc_ready (alloc_ready),
    .alloc_tag   (alloc_tag),
    .cmpl0_valid (cmpl0_valid),
    .cmpl0_tag   (cmpl0_tag),
    .cmpl0_data  (cmpl0_data),
    .cmpl1_valid (cmpl1_valid),
    .cmpl1_tag   (cmpl1_tag),
    .cmpl1_data  (cmpl1_data),
    .regWrite1   (regWrite1),
    .rd1         (rd1),
    .rd1_data    (rd1_data),
    .regWrite2   (regWrite2),
    .rd2         (rd2),
    .rd2_data    (rd2_data),
    .retire_count(retire_count),
    .rob_empty   (rob_empty)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: per-tag expected payload plus program-order queue of live tags.
  logic        exp_we   [16];
  logic [4:0]  exp_rd   [16];
  logic [31:0] exp_data [16];
  int          exp_q [$];
  int          mcnt  = 0;
  int          mtail = 0;

  task automatic check_eq(input string name, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) $display("FAIL %s: got %0h expected %0h", name, obs, exp);
    else n_pass++;
  endtask

  task automatic check_slot(input int k, input bit used, input logic rw, input logic [4:0] rd,
                            input logic [31:0] d);
    int t;
    if (used) begin
      if (exp_q.size() == 0) begin
        check_eq($sformatf("s%0d_underflow", k), 32'(exp_q.size()), 32'd1);
      end else begin
        t = exp_q.pop_front();
        mcnt--;
        check_eq($sformatf("s%0d_we", k), 32'(rw), 32'(exp_we[t]));
        check_eq($sformatf("s%0d_rd", k), 32'(rd), exp_we[t] ? 32'(exp_rd[t]) : 32'd0);
        check_eq($sformatf("s%0d_data", k), d, exp_we[t] ? exp_data[t] : 32'd0);
      end
    end else begin
      check_eq($sformatf("s%0d_idle", k), 32'(rw | (|rd) | (|d)), 32'd0);
    end
  endtask

  always @(posedge clk) begin
    #1;
    if (!reset) begin
      check_eq("rc_range", 32'(retire_count != 2'd3), 32'd1);
      check_slot(1, retire_count != 2'd0, regWrite1, rd1, rd1_data);
      check_slot(2, retire_count == 2'd2, regWrite2, rd2, rd2_data);
    end
  end

  task automatic clear_model();
    exp_q.delete();
    mcnt  = 0;
    mtail = 0;
  endtask

  // One cycle of stimulus, driven at the falling edge and released at the next one.
  task automatic drive_cycle(input bit av, input int ard, input bit awe,
                             input bit c0v, input int c0t, input logic [31:0] c0d,
                             input bit c1v, input int c1t, input logic [31:0] c1d);
    check_eq("alloc_ready", 32'(alloc_ready), 32'(mcnt < 16));
    check_eq("alloc_tag", 32'(alloc_tag), 32'(mtail));
    alloc_valid = av;
    alloc_rd    = 5'(ard);
    alloc_we    = awe;
    cmpl0_valid = c0v;
    cmpl0_tag   = 4'(c0t);
    cmpl0_data  = c0d;
    cmpl1_valid = c1v;
    cmpl1_tag   = 4'(c1t);
    cmpl1_data  = c1d;
    if (av && mcnt < 16) begin
      exp_we[mtail]   = awe;
      exp_rd[mtail]   = 5'(ard);
      exp_data[mtail] = 32'd0;
      exp_q.push_back(mtail);
      mtail = (mtail + 1) % 16;
      mcnt++;
    end
    if (c0v) exp_data[c0t % 16] = c0d;
    if (c1v) exp_data[c1t % 16] = c1d;
    @(negedge clk);
    alloc_valid = 1'b0;
    cmpl0_valid = 1'b0;
    cmpl1_valid = 1'b0;
  endtask

  task automatic alloc(input int rd, input bit we);
    drive_cycle(1'b1, rd, we, 1'b0, 0, 32'd0, 1'b0, 0, 32'd0);
  endtask

  task automatic cmpl(input int t, input logic [31:0] d);
    drive_cycle(1'b0, 0, 1'b0, 1'b1, t, d, 1'b0, 0, 32'd0);
  endtask

  task automatic idle();
    drive_cycle(1'b0, 0, 1'b0, 1'b0, 0, 32'd0, 1'b0, 0, 32'd0);
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    #1;
    clear_model();
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic drain(input string name);
    for (int i = 0; i < 60 && exp_q.size() != 0; i++) @(negedge clk);
    check_eq(name, 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    reset       = 1'b1;
    flush       = 1'b0;
    alloc_valid = 1'b0;
    alloc_rd    = '0;
    alloc_we    = 1'b0;
    cmpl0_valid = 1'b0;
    cmpl0_tag   = '0;
    cmpl0_data  = '0;
    cmpl1_valid = 1'b0;
    cmpl1_tag   = '0;
    cmpl1_data  = '0;
    for (int i = 0; i < 16; i++) begin
      exp_we[i]   = 1'b0;
      exp_rd[i]   = '0;
      exp_data[i] = '0;
    end

    // Reset state
    @(negedge clk);
    check_eq("rst_alloc_ready", 32'(alloc_ready), 32'd1);
    check_eq("rst_rob_empty", 32'(rob_empty), 32'd1);
    check_eq("rst_alloc_tag", 32'(alloc_tag), 32'd0);
    check_eq("rst_retire_count", 32'(retire_count), 32'd0);
    check_eq("rst_slots", 32'(regWrite1 | regWrite2 | (|rd1) | (|rd2) | (|rd1_data) |
                              (|rd2_data)), 32'd0);
    reset = 1'b0;

    // 1: in-order completion, one retire per cycle, one cycle after each completion edge
    alloc(5, 1'b1);
    alloc(6, 1'b1);
    alloc(7, 1'b1);
    cmpl(0, 32'h0000_0100);
    check_eq("t1_no_bypass", 32'(retire_count), 32'd0);
    cmpl(1, 32'h0000_0101);
    check_eq("t1_rc_a", 32'(retire_count), 32'd1);
    check_eq("t1_rd_a", 32'(rd1), 32'd5);
    cmpl(2, 32'h0000_0102);
    check_eq("t1_rc_b", 32'(retire_count), 32'd1);
    check_eq("t1_rd_b", 32'(rd1), 32'd6);
    idle();
    check_eq("t1_rc_c", 32'(retire_count), 32'd1);
    check_eq("t1_rd_c", 32'(rd1), 32'd7);
    check_eq("t1_empty", 32'(rob_empty), 32'd1);
    idle();
    check_eq("t1_rc_end", 32'(retire_count), 32'd0);

    // 2: younger completes first; both retire together once the head is done
    apply_reset();
    alloc(10, 1'b1);
    alloc(11, 1'b1);
    cmpl(1, 32'h0000_BEEF);
    check_eq("t2_wait_a", 32'(retire_count), 32'd0);
    idle();
    check_eq("t2_wait_b", 32'(retire_count), 32'd0);
    cmpl(0, 32'h0000_1234);
    check_eq("t2_wait_c", 32'(retire_count), 32'd0);
    idle();
    check_eq("t2_rc", 32'(retire_count), 32'd2);
    check_eq("t2_rd1_data", rd1_data, 32'h0000_1234);
    check_eq("t2_rd2_data", rd2_data, 32'h0000_BEEF);
    check_eq("t2_rw2", 32'(regWrite2), 32'd1);
    idle();
    check_eq("t2_empty", 32'(rob_empty), 32'd1);

    // 3: fill to DEPTH, ignored extra alloc, retire frees a slot, tail wraps to 0
    apply_reset();
    for (int i = 0; i < 16; i++) alloc(i + 1, 1'b1);
    check_eq("t3_full", 32'(alloc_ready), 32'd0);
    alloc(31, 1'b1);
    check_eq("t3_still_full", 32'(alloc_ready), 32'd0);
    cmpl(0, 32'hC000_0000);
    check_eq("t3_full_done", 32'(alloc_ready), 32'd0);
    idle();
    check_eq("t3_rc", 32'(retire_count), 32'd1);
    check_eq("t3_ready", 32'(alloc_ready), 32'd1);
    check_eq("t3_wrap_tag", 32'(alloc_tag), 32'd0);
    alloc(20, 1'b1);
    for (int k = 1; k < 16; k += 2)
      drive_cycle(1'b0, 0, 1'b0, 1'b1, k, 32'hC000_0000 + 32'(k),
                  1'b1, (k + 1) % 16, 32'hC000_0000 + 32'(k + 1));
    drain("t3_drain");

    // 4: both ports complete the same tag; port 1 data must retire
    apply_reset();
    for (int i = 0; i < 4; i++) alloc(i + 1, 1'b1);
    drive_cycle(1'b0, 0, 1'b0, 1'b1, 3, 32'h0000_AAAA, 1'b1, 3, 32'h0000_5555);
    drive_cycle(1'b0, 0, 1'b0, 1'b1, 0, 32'h0000_0A00, 1'b1, 1, 32'h0000_0A01);
    cmpl(2, 32'h0000_0A02);
    drain("t4_drain");

    // 5: entry without a destination write
    apply_reset();
    alloc(9, 1'b0);
    cmpl(0, 32'h0000_DEAD);
    idle();
    check_eq("t5_rc", 32'(retire_count), 32'd1);
    check_eq("t5_rw1", 32'(regWrite1), 32'd0);
    check_eq("t5_rd1", 32'(rd1), 32'd0);

    // 6: flush beats same-cycle alloc/complete, then async reset mid-run
    apply_reset();
    for (int i = 0; i < 5; i++) alloc(11 + i, 1'b1);
    drive_cycle(1'b0, 0, 1'b0, 1'b1, 1, 32'h0000_0F01, 1'b1, 2, 32'h0000_0F02);
    flush       = 1'b1;
    alloc_valid = 1'b1;
    alloc_rd    = 5'd30;
    alloc_we    = 1'b1;
    cmpl0_valid = 1'b1;
    cmpl0_tag   = 4'd0;
    cmpl0_data  = 32'h0000_0F00;
    cmpl1_valid = 1'b1;
    cmpl1_tag   = 4'd3;
    cmpl1_data  = 32'h0000_0F03;
    clear_model();
    @(negedge clk);
    flush       = 1'b0;
    alloc_valid = 1'b0;
    cmpl0_valid = 1'b0;
    cmpl1_valid = 1'b0;
    check_eq("t6_flush_rc", 32'(retire_count), 32'd0);
    check_eq("t6_flush_empty", 32'(rob_empty), 32'd1);
    check_eq("t6_flush_tag", 32'(alloc_tag), 32'd0);
    idle();
    idle();
    check_eq("t6_no_retire", 32'(retire_count), 32'd0);
    // Stale done bits from before the flush must not let tag 1 retire early.
    alloc(1, 1'b1);
    alloc(2, 1'b1);
    cmpl(0, 32'h0000_0077);
    idle();
    check_eq("t6_one_only", 32'(retire_count), 32'd1);
    cmpl(1, 32'h0000_0088);
    drain("t6_drain");
    alloc(3, 1'b1);
    alloc(4, 1'b1);
    drive_cycle(1'b0, 0, 1'b0, 1'b1, 2, 32'h0000_0033, 1'b1, 3, 32'h0000_0044);
    idle();
    check_eq("t6_pre_rst_rc", 32'(retire_count), 32'd2);
    #1;
    reset = 1'b1;
    #1;
    check_eq("t6_arst_rc", 32'(retire_count), 32'd0);
    check_eq("t6_arst_slots", 32'(regWrite1 | regWrite2 | (|rd1) | (|rd2) | (|rd1_data) |
                                  (|rd2_data)), 32'd0);
    check_eq("t6_arst_empty", 32'(rob_empty), 32'd1);
    check_eq("t6_arst_tag", 32'(alloc_tag), 32'd0);
    clear_model();
    @(negedge clk);
    reset = 1'b0;
    idle();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
